// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB4 completer with a byte-strobed register file, fixed wait states and PSLVERR.
// Optional feature macro: APB_PROT_CHECK_EN (rejects unprivileged writes to the upper half of the map).

// One byte column of the register file: byte 'lane' of every register.
module apb_regfile_lane #(
   parameter int NUM_REGS = 16,
   parameter int IW       = 4
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   input  logic                     we,
   input  logic [IW-1:0]            idx,
   input  logic [7:0]               wbyte,
   output logic [NUM_REGS-1:0][7:0] q
);
   always_ff @(posedge PCLK) begin
      if (PRESET)  q      <= '0;
      else if (we) q[idx] <= wbyte;
   end
endmodule

module apb_regfile_slave #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    STRB_WIDTH  = DATA_WIDTH/8,
   parameter int                    NUM_REGS    = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_4000,
   parameter int                    WAIT_STATES = 2,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [STRB_WIDTH-1:0] PSTRB,
   input  logic [2:0]            PPROT,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR,
   output logic [DATA_WIDTH-1:0] ctrl_out
);
   localparam int IW = $clog2(NUM_REGS);
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] offset;
   logic [IW-1:0]         idx;
   logic                  prot_err;
   logic                  err;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [STRB_WIDTH-1:0][NUM_REGS-1:0][7:0] lane_q;

   assign offset = PADDR - BASE_ADDR;
   assign idx    = offset[IW+1:2];

`ifdef APB_PROT_CHECK_EN
   logic [1:0] prot_unused;
   assign prot_unused = PPROT[2:1];
   assign prot_err    = PWRITE & ~PPROT[0] & (idx >= IW'(NUM_REGS/2));
`else
   logic prot_unused;
   assign prot_unused = ^PPROT;
   assign prot_err    = 1'b0;
`endif

   // Range check uses the full offset so that aliases of a valid index above the map still error.
   assign err = (PADDR < BASE_ADDR)
              | (offset >= ADDR_WIDTH'(4*NUM_REGS))
              | (PADDR[1:0] != 2'b00)
              | (PWRITE & (idx == '0))
              | (~PWRITE & (PSTRB != '0))
              | prot_err;

   assign PREADY  = (state == ACCESS) & PSEL & PENABLE & (cnt == '0);
   assign PSLVERR = PREADY & err;
   assign PRDATA  = (PREADY & ~PWRITE & ~err) ? ((idx == '0) ? ID_VALUE : rd_word) : '0;
   assign wr_en   = PREADY & PWRITE & ~err;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  state <= ACCESS;
                  cnt   <= CW'(WAIT_STATES);
               end
            end
            ACCESS: begin
               if (!PSEL || PREADY) state <= IDLE;
               else if (cnt != '0)  cnt   <= cnt - CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_lane
      apb_regfile_lane #(.NUM_REGS(NUM_REGS), .IW(IW)) u_lane (
         .PCLK  (PCLK),
         .PRESET(PRESET),
         .we    (wr_en & PSTRB[b]),
         .idx   (idx),
         .wbyte (PWDATA[8*b +: 8]),
         .q     (lane_q[b])
      );
      assign rd_word[8*b +: 8]  = lane_q[b][idx];
      assign ctrl_out[8*b +: 8] = lane_q[b][1];
   end
endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
APB4 completer (responder) that terminates transfers issued by the team's APB master on one select line. It holds a small word-addressed register file with byte-lane write strobes, a programmable wait-state count, and PSLVERR signalling for bad accesses. Register 1 is exported as a control word for downstream logic.

Parameters:
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width
STRB_WIDTH, DATA_WIDTH/8, PSTRB width
NUM_REGS, 16, number of 32-bit registers (power of 2, 2..256)
BASE_ADDR, 32'h0000_4000, byte address of register 0
WAIT_STATES, 2, extra access cycles before PREADY (0 = zero-wait)
ID_VALUE, 32'hA9B0_0001, read-only contents of register 0

Ports:
PCLK  in  1  clock; all state changes on posedge
PRESET  in  1  synchronous, active-high reset
PSEL  in  1  completer select
PENABLE  in  1  access phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  STRB_WIDTH  write byte-lane enables
PPROT  in  3  protection attributes
PREADY  out  1  transfer completes this cycle
PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1
PSLVERR  out  1  error response, valid when PREADY=1
ctrl_out  out  DATA_WIDTH  live value of register 1

Behaviour:
- Reset (PRESET=1 at posedge): FSM -> IDLE, wait counter 0, registers 1..NUM_REGS-1 = 0. While in IDLE, PREADY=0, PRDATA=0, PSLVERR=0; ctrl_out=0. Reset wins over any transfer in flight; no write commits on a reset edge.
- FSM states: IDLE, ACCESS.
  - IDLE: PSEL=1 and PENABLE=0 (setup) -> ACCESS, counter loaded with WAIT_STATES.
  - ACCESS: counter decrements each cycle while nonzero. PREADY = PSEL & PENABLE & (counter==0), combinational from registered state. Completion cycle (PREADY=1): next state ACCESS-reload is not allowed; go to IDLE. A following setup cycle is taken from IDLE, so back-to-back transfers need no idle gap.
  - ACCESS with PSEL=0 (master abort): -> IDLE, no write, no error.
- Latency: setup at cycle T; PREADY high in cycle T+1+WAIT_STATES.
- Decode: offset = PADDR - BASE_ADDR; index = offset[log2(NUM_REGS)+1:2]. err = (PADDR < BASE_ADDR) | (offset >= 4*NUM_REGS) | (PADDR[1:0] != 0) | (PWRITE & index==0) | (!PWRITE & PSTRB != 0).
- Write: on the completion edge with PWRITE=1 and err=0, byte lane i of reg[index] takes PWDATA[8i+7:8i] where PSTRB[i]=1; other lanes hold. PSTRB=0 is a legal write that changes nothing.
- Read: during completion cycle, PRDATA = (index==0 ? ID_VALUE : reg[index]) when err=0, else 0. PRDATA=0 in every cycle where PREADY=0.
- PSLVERR = PREADY & err; 0 otherwise. An erroring write never modifies any register.
- ctrl_out updates the cycle after the committing edge (register output).
- PADDR/PWRITE/PWDATA/PSTRB are sampled in the completion cycle; the master holds them stable per APB.

Optional Feature:
APB_PROT_CHECK_EN: when defined, a write with PPROT[0]=0 (unprivileged) to any index >= NUM_REGS/2 is added to err (PSLVERR=1, no update); reads are unaffected. When not defined, PPROT is ignored entirely.

Test Plan:
- Reset then zero-traffic: PRESET=1 for 2 cycles -> PREADY=0, PRDATA=0, PSLVERR=0, ctrl_out=0.
- Write 32'hDEAD_BEEF to 32'h4004 with PSTRB=4'hF, WAIT_STATES=2 -> PREADY high exactly 3 cycles after setup, PSLVERR=0, ctrl_out=32'hDEAD_BEEF next cycle; read back returns 32'hDEAD_BEEF.
- Partial write 32'h1122_3344 to 32'h4004 with PSTRB=4'b0101 -> read returns 32'hDE22_BE44.
- Error cases: write to 32'h4000 (ID), read 32'h4002 (misaligned), read 32'h4040 (out of range, NUM_REGS=16) -> each completes with PSLVERR=1, PRDATA=0; a read of 32'h4000 returns 32'hA9B0_0001, PSLVERR=0.
- Reset mid-transfer: assert PRESET during a wait state of a write to 32'h4008 -> no PREADY, reg 2 reads 0 after reset.
- With APB_PROT_CHECK_EN: write 32'h55 to 32'h4020 with PPROT=3'b000 -> PSLVERR=1, read returns 0; same write with PPROT=3'b001 -> PSLVERR=0, read returns 32'h55.
